// File: rtl/kmeans_pkg.sv
// kmeans_pkg
// Shared definitions for the K-means pass scheduler: FSM state encoding,
// IEEE-754 single-precision field positions, the default convergence
// threshold and small float helpers used by the convergence check.
package kmeans_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_DRAIN,
        ST_CHECK,
        ST_LABEL_SWEEP,
        ST_LABEL_DRAIN,
        ST_FINISH
    } kmeans_state_e;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;

    localparam int ITER_W = 5;

    // 0.01 in single precision
    localparam logic [31:0] DELTA_THRESH_DEF = 32'h3C23D70A;

    function automatic logic f32_is_nan(input logic [31:0] f);
        return (&f[EXP_MSB:EXP_LSB]) && (|f[EXP_LSB-1:0]);
    endfunction

    // Magnitude compare: with the sign bit dropped, the ordering of
    // non-negative IEEE-754 values matches unsigned integer ordering.
    function automatic logic f32_mag_below(input logic [31:0] f, input logic [31:0] thr);
        return !f32_is_nan(f) && (f[EXP_MSB:0] < thr[EXP_MSB:0]);
    endfunction

endpackage

// File: rtl/kmeans_addr_sweeper.sv
// kmeans_addr_sweeper
// Pixel address generator shared by the clustering and labelling sweeps.
// Issues one read per cycle while enabled and the core is ready, wraps to 0
// after the last pixel, and delays the read strobe plus first/last flags by
// the BRAM read latency so they line up with the BRAM output data.
//
// Ports:
//   clk_i, reset_i   clock, synchronous active-high reset
//   clr_i            force the address counter back to 0 (job start)
//   en_i             a sweep state is active
//   ready_i          core accepts a pixel this cycle
//   addr_o           current read address
//   rd_en_o          read strobe (en_i & ready_i)
//   last_issue_o     rd_en_o on the last pixel address
//   pix_valid_o      rd_en_o delayed by RD_LAT
//   first_o, last_o  address-0 / address-(NUM_PIXELS-1) flags delayed by RD_LAT
module kmeans_addr_sweeper
    import kmeans_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int NUM_PIXELS = 16384,
    parameter int RD_LAT     = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic              ready_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              rd_en_o,
    output logic              last_issue_o,
    output logic              pix_valid_o,
    output logic              first_o,
    output logic              last_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [RD_LAT-1:0] vld_q, first_q, last_q;
    logic              rd_en;
    logic              at_last;

    assign rd_en   = en_i & ready_i;
    assign at_last = (addr_q == LAST_ADDR);

    always_comb begin
        addr_d = addr_q;
        if (clr_i) begin
            addr_d = '0;
        end else if (rd_en) begin
            addr_d = at_last ? '0 : addr_q + ADDR_W'(1);
        end
    end

    // The delay line runs regardless of sweep state so pixels issued in the
    // last sweep cycle still reach the core after the FSM has moved on.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            addr_q  <= '0;
            vld_q   <= '0;
            first_q <= '0;
            last_q  <= '0;
        end else begin
            addr_q     <= addr_d;
            vld_q[0]   <= rd_en;
            first_q[0] <= rd_en && (addr_q == '0);
            last_q[0]  <= rd_en && at_last;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i]   <= vld_q[i-1];
                first_q[i] <= first_q[i-1];
                last_q[i]  <= last_q[i-1];
            end
        end
    end

    assign addr_o       = addr_q;
    assign rd_en_o      = rd_en;
    assign last_issue_o = rd_en && at_last;
    assign pix_valid_o  = vld_q[RD_LAT-1];
    assign first_o      = first_q[RD_LAT-1];
    assign last_o       = last_q[RD_LAT-1];

endmodule

// File: rtl/kmeans_pass_scheduler.sv
// kmeans_pass_scheduler
// Runs clustering passes of the K-means core over the CIE-A pixel buffer
// until the centroid delta drops below threshold or the iteration cap is hit,
// then runs one labelling pass that writes 1-bit cluster IDs.
//
// Ports:
//   clk_i, reset_i           clock, synchronous active-high reset
//   start_i                  begin a job (ignored unless idle)
//   busy_o, done_o           job in progress / single-cycle completion pulse
//   converged_o              threshold met before the iteration cap
//   iter_count_o             clustering passes executed
//   pix_addr_o, pix_rd_en_o  CIE-A read port
//   core_*                   pixel stream to and results from the core
//   cid_addr_o, cid_we_o, cid_wdata_o  cluster-ID memory write port
//
// state          | meaning
// ---------------+----------------------------------------------------
// ST_IDLE        | waiting for start
// ST_SWEEP       | issuing pixel reads for a clustering pass
// ST_DRAIN       | waiting for the core's end-of-pass delta
// ST_CHECK       | convergence / iteration-cap decision
// ST_LABEL_SWEEP | issuing pixel reads for the labelling pass
// ST_LABEL_DRAIN | all reads issued, collecting remaining cluster IDs
// ST_FINISH      | done pulse, back to idle
module kmeans_pass_scheduler
    import kmeans_pkg::*;
#(
    parameter int          ADDR_W       = 16,
    parameter int          NUM_PIXELS   = 16384,
    parameter int          MAX_ITER     = 16,
    parameter logic [31:0] DELTA_THRESH = DELTA_THRESH_DEF,
    parameter int          RD_LAT       = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              converged_o,
    output logic [4:0]        iter_count_o,
    output logic [ADDR_W-1:0] pix_addr_o,
    output logic              pix_rd_en_o,
    input  logic              core_ready_i,
    output logic              core_pix_valid_o,
    output logic              core_first_o,
    output logic              core_last_o,
    output logic              core_label_mode_o,
    input  logic              core_pass_done_i,
    input  logic [31:0]       core_delta_i,
    input  logic              core_cid_valid_i,
    input  logic              core_cid_i,
    output logic [ADDR_W-1:0] cid_addr_o,
    output logic              cid_we_o,
    output logic              cid_wdata_o
);

    localparam logic [ADDR_W:0]   NUM_CNT  = (ADDR_W+1)'(NUM_PIXELS);
    localparam logic [ADDR_W:0]   LAST_WR  = NUM_CNT - (ADDR_W+1)'(1);
    localparam logic [ITER_W-1:0] ITER_CAP = ITER_W'(MAX_ITER);

    kmeans_state_e     state_q, state_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic              conv_q, conv_d;
    logic [31:0]       delta_q, delta_d;
    logic [ADDR_W:0]   wr_cnt_q, wr_cnt_d;
    logic              cid_we_q, cid_we_d;
    logic              cid_wdata_q, cid_wdata_d;
    logic [ADDR_W-1:0] cid_addr_q, cid_addr_d;

    logic start_accept;
    logic sweep_en;
    logic label_state;
    logic last_issue;
    logic cid_accept;
    logic last_write;
    logic below;

    assign start_accept = (state_q == ST_IDLE) && start_i;
    assign sweep_en     = (state_q == ST_SWEEP) || (state_q == ST_LABEL_SWEEP);
    assign label_state  = (state_q == ST_LABEL_SWEEP) || (state_q == ST_LABEL_DRAIN);
    // Counter saturates at NUM_PIXELS so surplus labels are dropped.
    assign cid_accept   = label_state && core_cid_valid_i && (wr_cnt_q != NUM_CNT);
    assign last_write   = cid_accept && (wr_cnt_q == LAST_WR);
    assign below        = f32_mag_below(delta_q, DELTA_THRESH);

    kmeans_addr_sweeper #(
        .ADDR_W     (ADDR_W),
        .NUM_PIXELS (NUM_PIXELS),
        .RD_LAT     (RD_LAT)
    ) u_sweeper (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .clr_i        (start_accept),
        .en_i         (sweep_en),
        .ready_i      (core_ready_i),
        .addr_o       (pix_addr_o),
        .rd_en_o      (pix_rd_en_o),
        .last_issue_o (last_issue),
        .pix_valid_o  (core_pix_valid_o),
        .first_o      (core_first_o),
        .last_o       (core_last_o)
    );

    always_comb begin
        state_d     = state_q;
        iter_d      = iter_q;
        conv_d      = conv_q;
        delta_d     = delta_q;
        wr_cnt_d    = wr_cnt_q;
        cid_we_d    = 1'b0;
        cid_wdata_d = cid_wdata_q;
        cid_addr_d  = cid_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d  = ST_SWEEP;
                    iter_d   = '0;
                    conv_d   = 1'b0;
                    wr_cnt_d = '0;
                end
            end
            ST_SWEEP: begin
                if (last_issue) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (core_pass_done_i) begin
                    state_d = ST_CHECK;
                    iter_d  = iter_q + ITER_W'(1);
                    delta_d = core_delta_i;
                end
            end
            ST_CHECK: begin
                // Threshold wins over the cap when both hold on the final pass.
                if (below) begin
                    conv_d  = 1'b1;
                    state_d = ST_LABEL_SWEEP;
                end else if (iter_q == ITER_CAP) begin
                    conv_d  = 1'b0;
                    state_d = ST_LABEL_SWEEP;
                end else begin
                    state_d = ST_SWEEP;
                end
            end
            ST_LABEL_SWEEP: begin
                if (last_write)      state_d = ST_FINISH;
                else if (last_issue) state_d = ST_LABEL_DRAIN;
            end
            ST_LABEL_DRAIN: begin
                if (last_write) state_d = ST_FINISH;
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (cid_accept) begin
            cid_we_d    = 1'b1;
            cid_wdata_d = core_cid_i;
            cid_addr_d  = wr_cnt_q[ADDR_W-1:0];
            wr_cnt_d    = wr_cnt_q + (ADDR_W+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            iter_q      <= '0;
            conv_q      <= 1'b0;
            delta_q     <= '0;
            wr_cnt_q    <= '0;
            cid_we_q    <= 1'b0;
            cid_wdata_q <= 1'b0;
            cid_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            iter_q      <= iter_d;
            conv_q      <= conv_d;
            delta_q     <= delta_d;
            wr_cnt_q    <= wr_cnt_d;
            cid_we_q    <= cid_we_d;
            cid_wdata_q <= cid_wdata_d;
            cid_addr_q  <= cid_addr_d;
        end
    end

    assign busy_o            = (state_q != ST_IDLE);
    assign done_o            = (state_q == ST_FINISH);
    assign converged_o       = conv_q;
    assign iter_count_o      = iter_q;
    assign core_label_mode_o = label_state;
    assign cid_addr_o        = cid_addr_q;
    assign cid_we_o          = cid_we_q;
    assign cid_wdata_o       = cid_wdata_q;

endmodule

// File: doc/kmeans_pass_scheduler.md
Name: kmeans_pass_scheduler

Overview:
- Sequences the pipelined K-means core over the CIE-A pixel buffer.
- Sweeps pixel addresses for each clustering pass and waits for the core's end-of-pass centroid delta.
- Decides convergence (threshold or iteration cap), then runs one final labelling pass that writes 1-bit cluster IDs into the cluster-ID memory.
- Sits between the top-level controller's start/done handshake and the core/BRAM pair.

Parameters:
- ADDR_W, 16, pixel and cluster-ID address width
- NUM_PIXELS, 16384, pixels per pass; must satisfy 1 ≤ NUM_PIXELS ≤ 2^ADDR_W
- MAX_ITER, 16, maximum clustering passes before the forced label pass
- DELTA_THRESH, 32'h3C23D70A, IEEE-754 single-precision convergence threshold (0.01)
- RD_LAT, 1, CIE-A BRAM read latency in cycles

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to begin a clustering job
- busy  out  1  high from the cycle after accepted start until the done cycle
- done  out  1  single-cycle pulse at job completion
- converged  out  1  valid with done; 1 if the threshold was met before MAX_ITER
- iter_count  out  5  clustering passes executed; held after done
- pix_addr  out  ADDR_W  CIE-A read address
- pix_rd_en  out  1  CIE-A read enable
- core_ready  in  1  core accepts a pixel this cycle
- core_pix_valid  out  1  pix_rd_en delayed by RD_LAT; pixel data on the BRAM dout is valid
- core_first  out  1  aligned with core_pix_valid for address 0
- core_last  out  1  aligned with core_pix_valid for address NUM_PIXELS-1
- core_label_mode  out  1  1 during the final labelling pass
- core_pass_done  in  1  pulse: core finished a pass and updated centroids
- core_delta  in  32  float |max centroid movement|, valid with core_pass_done
- core_cid_valid  in  1  label output valid
- core_cid  in  1  cluster ID of the next pixel, in address order
- cid_addr  out  ADDR_W  cluster-ID memory write address
- cid_we  out  1  cluster-ID write enable
- cid_wdata  out  1  cluster-ID write data

Behaviour:
- Reset: all outputs 0; FSM to IDLE; address, write and iteration counters cleared. Reset mid-job aborts immediately with no done pulse.
- FSM states: IDLE, SWEEP, DRAIN, CHECK, LABEL_SWEEP, LABEL_DRAIN, FINISH.
- IDLE:
  - start → SWEEP. Clears iter_count and converged; sets busy next cycle.
  - start while busy is ignored.
- SWEEP:
  - pix_rd_en = core_ready. pix_addr increments only on cycles where pix_rd_en=1.
  - When address NUM_PIXELS-1 is issued → DRAIN. The address counter returns to 0.
  - Stalls (core_ready=0) hold pix_addr and assert no read.
- core_pix_valid, core_first and core_last form an RD_LAT-deep shift of pix_rd_en and the address flags. They are independent of the FSM state, so trailing pixels still reach the core after leaving SWEEP.
- DRAIN: waits for core_pass_done, then → CHECK. iter_count increments in the same cycle.
  - core_pass_done in any other state is ignored.
  - core_pass_done already high during the last SWEEP cycle is ignored; only a pulse in DRAIN counts.
- CHECK (1 cycle):
  - below = (core_delta[30:0] < DELTA_THRESH[30:0]). The sign bit is ignored, so the comparison is unsigned integer on magnitude bits.
  - core_delta is captured in DRAIN.
  - below → converged=1, go to LABEL_SWEEP.
  - else if iter_count == MAX_ITER → converged=0, go to LABEL_SWEEP.
  - else → SWEEP.
  - A NaN delta (exponent all-ones, nonzero mantissa) counts as not below.
- LABEL_SWEEP: identical to SWEEP, with core_label_mode=1. core_label_mode is asserted from entry until FINISH.
- Label writes:
  - Each core_cid_valid in LABEL_SWEEP/LABEL_DRAIN produces cid_we=1 on the next cycle, with cid_wdata=core_cid and cid_addr = write counter. The counter then increments.
  - After NUM_PIXELS writes → FINISH.
  - core_cid_valid outside the label states is ignored.
  - Extra core_cid_valid beyond NUM_PIXELS is ignored; the counter saturates.
- LABEL_SWEEP → LABEL_DRAIN after the last address. If the last write and the last address coincide, go directly to FINISH.
- FINISH (1 cycle): done=1, busy=0 next cycle, core_label_mode=0, then IDLE.
  - start coincident with done is ignored.
- Minimum job latency: 2·NUM_PIXELS + core latency + 4 cycles.

Decomposition:
- Shared package kmeans_pkg:
  - FSM state enum
  - float field constants: SIGN_BIT=31, EXP_MSB=30, EXP_LSB=23
  - default threshold DELTA_THRESH_DEF
- One natural sub-module: kmeans_addr_sweeper. It owns the address counter, the stall handling, and the RD_LAT-delayed valid/first/last. It is instantiated once and reused for both sweep types.

Test Plan:
- NUM_PIXELS=8, core_ready=1, delta=0x00000000 at the first pass_done → iter_count=1, converged=1; addresses 0..7 issued twice; 8 cid writes to addresses 0..7; one done pulse.
- delta always 0x42C80000 (100.0), MAX_ITER=3 → exactly 3 clustering passes, then a label pass; converged=0, iter_count=3.
- core_ready toggling every cycle during SWEEP → pix_addr advances only on ready cycles; core_first at addr 0, core_last at addr 7; no address skipped or duplicated.
- delta=0xBC23D709 (negative, magnitude below threshold) → converged=1; delta=0x3C23D70A (equal to threshold) → not converged.
- Reset asserted mid-DRAIN → the next cycle has all outputs 0 and no done pulse; a new start runs a full job normally.
- start pulsed while busy, plus core_pass_done injected during SWEEP → both ignored; iteration count unchanged.
